// File: rtl/gmii_testframe_checker.sv
// GMII receive-side testframe parser. Strips preamble/SFD, timestamps each frame at the SFD,
// checks the FCS, extracts the seq/sec/nsec trailer placed just before the FCS, and emits one
// registered result record per frame with latency and sequence-gap status.
module gmii_testframe_checker #(
  parameter int unsigned C_NSEC_PER_SEC  = 1000000000,
  parameter int unsigned C_MAX_PREAMBLE  = 7,
  parameter int unsigned C_MIN_TESTFRAME = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  gmii_d,
  input  logic        gmii_en,
  input  logic        gmii_er,
  input  logic [47:0] sec,
  input  logic [29:0] nsec,
  output logic        o_valid,
  output logic [15:0] o_frame_size,
  output logic        o_fcs_ok,
  output logic        o_rx_error,
  output logic        o_is_testframe,
  output logic [63:0] o_seq,
  output logic        o_seq_err,
  output logic [47:0] o_rx_sec,
  output logic [29:0] o_rx_nsec,
  output logic [31:0] o_latency_nsec,
  output logic        o_latency_valid
);

  localparam logic [7:0]  PreambleByte = 8'h55;
  localparam logic [7:0]  SfdByte      = 8'hD5;
  localparam logic [31:0] CrcInit      = 32'hFFFF_FFFF;
  localparam logic [31:0] CrcPoly      = 32'hEDB8_8320;
  localparam logic [31:0] CrcResidue   = 32'hDEBB_20E3;
  localparam logic [15:0] TrailerBytes = 16'd22;
  localparam logic [7:0]  MaxPreamble  = 8'(C_MAX_PREAMBLE);
  localparam logic [15:0] MinTestframe = 16'(C_MIN_TESTFRAME);
  localparam logic [31:0] NsecPerSec   = 32'(C_NSEC_PER_SEC);

  typedef enum logic [1:0] {
    StIdle,
    StPreamble,
    StData,
    StDrop
  } state_e;

  // One byte of the reflected CRC-32, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ CrcPoly;
      else             r = r >> 1;
    end
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  pre_cnt_q, pre_cnt_d;
  logic        sfd_seen;
  logic        data_beat;
  logic        frame_end;

  // Per-frame accumulation.
  logic [31:0]  crc_q;
  logic [15:0]  size_q;
  logic         er_q;
  logic [31:0]  fcs_win_q;      // newest 4 bytes (the FCS once the frame ends)
  logic [143:0] trl_win_q;      // the 18 bytes before those: seq, sec, nsec
  logic [47:0]  rx_sec_q;
  logic [29:0]  rx_nsec_q;

  // Stage 1: frame snapshot and timestamp deltas.
  logic         s1_valid_q;
  logic [15:0]  s1_size_q;
  logic         s1_fcs_ok_q;
  logic         s1_er_q;
  logic [63:0]  s1_seq_q;
  logic [47:0]  s1_rx_sec_q;
  logic [29:0]  s1_rx_nsec_q;
  logic         s1_tx_nsec_ok_q;
  logic         s1_dsec_zero_q;
  logic         s1_dsec_one_q;
  logic         s1_nsec_ge_q;
  logic [31:0]  s1_nsec_direct_q;
  logic [31:0]  s1_nsec_wrap_q;

  // Trailer fields of the frame just finished, zero when it is too short to hold one.
  logic         has_trailer;
  logic [63:0]  tr_seq;
  logic [47:0]  tr_sec;
  logic [31:0]  tr_nsec;
  logic [47:0]  dsec;

  logic [63:0]  exp_seq_q;
  logic         s2_is_tf;
  logic         s2_lat_ok;
  logic [31:0]  s2_latency;
  logic         s2_seq_err;

  // FSM state register; reset lands in DROP if a frame is already on the wire.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= gmii_en ? StDrop : StIdle;
      pre_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
    end
  end

  // FSM next state and per-cycle strobes.
  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    sfd_seen  = 1'b0;
    data_beat = 1'b0;
    frame_end = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (gmii_en) begin
          if (gmii_d == PreambleByte) begin
            state_d   = StPreamble;
            pre_cnt_d = 8'd1;
          end else begin
            state_d = StDrop;
          end
        end
      end
      StPreamble: begin
        if (!gmii_en) begin
          state_d = StIdle;
        end else if (gmii_d == PreambleByte) begin
          if (pre_cnt_q < MaxPreamble) pre_cnt_d = pre_cnt_q + 8'd1;
          else                         state_d   = StDrop;
        end else if (gmii_d == SfdByte) begin
          state_d  = StData;
          sfd_seen = 1'b1;
        end else begin
          state_d = StDrop;
        end
      end
      StData: begin
        if (gmii_en) begin
          data_beat = 1'b1;
        end else begin
          state_d   = StIdle;
          frame_end = 1'b1;
        end
      end
      StDrop: begin
        if (!gmii_en) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Frame accumulation: CRC, saturating size, sticky error, trailer window, SFD timestamp.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q     <= CrcInit;
      size_q    <= '0;
      er_q      <= 1'b0;
      fcs_win_q <= '0;
      trl_win_q <= '0;
      rx_sec_q  <= '0;
      rx_nsec_q <= '0;
    end else if (sfd_seen) begin
      crc_q     <= CrcInit;
      size_q    <= '0;
      er_q      <= 1'b0;
      fcs_win_q <= '0;
      trl_win_q <= '0;
      rx_sec_q  <= sec;
      rx_nsec_q <= nsec;
    end else if (data_beat) begin
      crc_q     <= crc_byte(crc_q, gmii_d);
      size_q    <= (size_q == 16'hFFFF) ? size_q : size_q + 16'd1;
      er_q      <= er_q | gmii_er;
      fcs_win_q <= {fcs_win_q[23:0], gmii_d};
      trl_win_q <= {trl_win_q[135:0], fcs_win_q[31:24]};
    end
  end

  // Trailer extraction and second/nanosecond deltas feeding stage 1.
  always_comb begin
    has_trailer = (size_q >= TrailerBytes);
    tr_seq      = has_trailer ? trl_win_q[143:80] : '0;
    tr_sec      = has_trailer ? trl_win_q[79:32]  : '0;
    tr_nsec     = has_trailer ? trl_win_q[31:0]   : '0;
    dsec        = rx_sec_q - tr_sec;
  end

  // Stage 1: capture the finished frame so a new one can start on the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q       <= 1'b0;
      s1_size_q        <= '0;
      s1_fcs_ok_q      <= 1'b0;
      s1_er_q          <= 1'b0;
      s1_seq_q         <= '0;
      s1_rx_sec_q      <= '0;
      s1_rx_nsec_q     <= '0;
      s1_tx_nsec_ok_q  <= 1'b0;
      s1_dsec_zero_q   <= 1'b0;
      s1_dsec_one_q    <= 1'b0;
      s1_nsec_ge_q     <= 1'b0;
      s1_nsec_direct_q <= '0;
      s1_nsec_wrap_q   <= '0;
    end else begin
      s1_valid_q <= frame_end;
      if (frame_end) begin
        s1_size_q        <= size_q;
        s1_fcs_ok_q      <= (crc_q == CrcResidue);
        s1_er_q          <= er_q;
        s1_seq_q         <= tr_seq;
        s1_rx_sec_q      <= rx_sec_q;
        s1_rx_nsec_q     <= rx_nsec_q;
        s1_tx_nsec_ok_q  <= (tr_nsec < NsecPerSec);
        s1_dsec_zero_q   <= (dsec == 48'd0);
        s1_dsec_one_q    <= (dsec == 48'd1);
        s1_nsec_ge_q     <= ({2'b00, rx_nsec_q} >= tr_nsec);
        s1_nsec_direct_q <= {2'b00, rx_nsec_q} - tr_nsec;
        s1_nsec_wrap_q   <= {2'b00, rx_nsec_q} + NsecPerSec - tr_nsec;
      end
    end
  end

  // Stage 2 decisions: testframe qualification, latency selection, sequence check.
  always_comb begin
    s2_is_tf   = s1_fcs_ok_q & ~s1_er_q & (s1_size_q >= MinTestframe) & s1_tx_nsec_ok_q;
    s2_lat_ok  = s2_is_tf & ((s1_dsec_zero_q & s1_nsec_ge_q) | s1_dsec_one_q);
    s2_latency = '0;
    if (s2_lat_ok) s2_latency = s1_dsec_one_q ? s1_nsec_wrap_q : s1_nsec_direct_q;
    s2_seq_err = s2_is_tf & (s1_seq_q != exp_seq_q);
  end

  // Stage 2 output record; fields hold until the next record, o_valid pulses once.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid         <= 1'b0;
      o_frame_size    <= '0;
      o_fcs_ok        <= 1'b0;
      o_rx_error      <= 1'b0;
      o_is_testframe  <= 1'b0;
      o_seq           <= '0;
      o_seq_err       <= 1'b0;
      o_rx_sec        <= '0;
      o_rx_nsec       <= '0;
      o_latency_nsec  <= '0;
      o_latency_valid <= 1'b0;
      exp_seq_q       <= '0;
    end else begin
      o_valid <= s1_valid_q;
      if (s1_valid_q) begin
        o_frame_size    <= s1_size_q;
        o_fcs_ok        <= s1_fcs_ok_q;
        o_rx_error      <= s1_er_q;
        o_is_testframe  <= s2_is_tf;
        o_seq           <= s1_seq_q;
        o_seq_err       <= s2_seq_err;
        o_rx_sec        <= s1_rx_sec_q;
        o_rx_nsec       <= s1_rx_nsec_q;
        o_latency_nsec  <= s2_latency;
        o_latency_valid <= s2_lat_ok;
        // Only testframes advance the expected sequence; 64-bit wrap is natural.
        if (s2_is_tf) exp_seq_q <= s1_seq_q + 64'd1;
      end
    end
  end

endmodule

// File: tb/tb_gmii_testframe_checker.sv
// Directed, table-driven bench for gmii_testframe_checker.
module tb_gmii_testframe_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  gmii_d;
  logic        gmii_en;
  logic        gmii_er;
  logic [47:0] sec;
  logic [29:0] nsec;
  logic        o_valid;
  logic [15:0] o_frame_size;
  logic        o_fcs_ok;
  logic        o_rx_error;
  logic        o_is_testframe;
  logic [63:0] o_seq;
  logic        o_seq_err;
  logic [47:0] o_rx_sec;
  logic [29:0] o_rx_nsec;
  logic [31:0] o_latency_nsec;
  logic        o_latency_valid;

  gmii_testframe_checker dut (
    .clk             (clk),
    .rst             (rst),
    .gmii_d          (gmii_d),
    .gmii_en         (gmii_en),
    .gmii_er         (gmii_er),
    .sec             (sec),
    .nsec            (nsec),
    .o_valid         (o_valid),
    .o_frame_size    (o_frame_size),
    .o_fcs_ok        (o_fcs_ok),
    .o_rx_error      (o_rx_error),
    .o_is_testframe  (o_is_testframe),
    .o_seq           (o_seq),
    .o_seq_err       (o_seq_err),
    .o_rx_sec        (o_rx_sec),
    .o_rx_nsec       (o_rx_nsec),
    .o_latency_nsec  (o_latency_nsec),
    .o_latency_valid (o_latency_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    int          pre;
    logic [63:0] seq;
    logic [47:0] txs;
    logic [31:0] txn;
    logic [47:0] rxs;
    logic [29:0] rxn;
    int          flip;
    int          er_at;
    logic        fcs_ok;
    logic        rx_err;
    logic        is_tf;
    logic        seq_err;
    logic [31:0] lat;
    logic        lat_v;
    logic [63:0] oseq;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  int          pulses = 0;
  logic [7:0]  fb[$];
  vec_t        tv[$];

  always @(negedge clk) if (o_valid) pulses++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int len, int pre, logic [63:0] seq, logic [47:0] txs,
                              logic [31:0] txn, logic [47:0] rxs, logic [29:0] rxn,
                              int flip, int er_at, logic fcs_ok, logic rx_err, logic is_tf,
                              logic seq_err, logic [31:0] lat, logic lat_v, logic [63:0] oseq);
    vec_t v;
    v.len = len; v.pre = pre; v.seq = seq; v.txs = txs; v.txn = txn; v.rxs = rxs;
    v.rxn = rxn; v.flip = flip; v.er_at = er_at; v.fcs_ok = fcs_ok; v.rx_err = rx_err;
    v.is_tf = is_tf; v.seq_err = seq_err; v.lat = lat; v.lat_v = lat_v; v.oseq = oseq;
    return v;
  endfunction

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic        fb_bit;
    r = c;
    for (int k = 0; k < 8; k++) begin
      fb_bit = r[0] ^ b[k];
      r = {1'b0, r[31:1]};
      if (fb_bit) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  // Post-SFD bytes: filler, 18-byte trailer (if len >= 22), then FCS LSB first.
  task automatic build_frame(input int len, input logic [63:0] seq, input logic [47:0] txs,
                             input logic [31:0] txn, input int flip);
    logic [143:0] tr;
    logic [31:0]  crc;
    logic [7:0]   b;
    int           plen;
    tr   = {seq, txs, txn};
    plen = len - 4;
    fb.delete();
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < plen; i++) begin
      if (len >= 22 && i >= plen - 18) b = tr[8*(17-(i-(plen-18))) +: 8];
      else                             b = 8'(i) ^ 8'h3C;
      fb.push_back(b);
      crc = crc_upd(crc, b);
    end
    crc = ~crc;
    fb.push_back(crc[7:0]);
    fb.push_back(crc[15:8]);
    fb.push_back(crc[23:16]);
    fb.push_back(crc[31:24]);
    if (flip >= 0) fb[flip] = fb[flip] ^ 8'h01;
  endtask

  task automatic cyc(input logic [7:0] d, input logic en, input logic er);
    gmii_d = d; gmii_en = en; gmii_er = er;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input int pre, input int er_at);
    for (int i = 0; i < pre; i++) cyc(8'h55, 1'b1, 1'b0);
    cyc(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < fb.size(); i++) cyc(fb[i], 1'b1, (i == er_at));
  endtask

  task automatic check_record(input string tag, input vec_t v);
    chk({tag, " valid"},    64'(o_valid), 64'd1);
    chk({tag, " size"},     64'(o_frame_size), 64'(v.len));
    chk({tag, " fcs_ok"},   64'(o_fcs_ok), 64'(v.fcs_ok));
    chk({tag, " rx_err"},   64'(o_rx_error), 64'(v.rx_err));
    chk({tag, " is_tf"},    64'(o_is_testframe), 64'(v.is_tf));
    chk({tag, " seq"},      o_seq, v.oseq);
    chk({tag, " seq_err"},  64'(o_seq_err), 64'(v.seq_err));
    chk({tag, " rx_sec"},   64'(o_rx_sec), 64'(v.rxs));
    chk({tag, " rx_nsec"},  64'(o_rx_nsec), 64'(v.rxn));
    chk({tag, " latency"},  64'(o_latency_nsec), 64'(v.lat));
    chk({tag, " lat_v"},    64'(o_latency_valid), 64'(v.lat_v));
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    sec  = v.rxs;
    nsec = v.rxn;
    build_frame(v.len, v.seq, v.txs, v.txn, v.flip);
    drive_frame(v.pre, v.er_at);
    cyc(8'h00, 1'b0, 1'b0);   // cycle E
    cyc(8'h00, 1'b0, 1'b0);   // cycle E+1
    check_record(tag, v);     // cycle E+2
    cyc(8'h00, 1'b0, 1'b0);
    chk({tag, " pulse_end"}, 64'(o_valid), 64'd0);
    chk({tag, " hold_seq"},  o_seq, v.oseq);
    repeat (9) cyc(8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    vec_t va, vb, vr;
    int   p0;

    // len pre seq txs txn rxs rxn flip er fcs rxe tf serr lat latv oseq
    tv.push_back(mk(64, 7, 0, 123, 1000, 123, 1800, -1, -1, 1, 0, 1, 0, 800, 1, 0));
    for (int i = 1; i <= 9; i++)
      tv.push_back(mk(64 + 4*i, 7, 64'(i), 123, 1000, 123, 30'(1800 + i), -1, -1,
                      1, 0, 1, 0, 32'(800 + i), 1, 64'(i)));
    tv.push_back(mk(64, 7, 11, 123, 1000, 123, 1800, -1, -1, 1, 0, 1, 1, 800, 1, 11));
    tv.push_back(mk(64, 7, 12, 123, 1000, 123, 1800, -1, -1, 1, 0, 1, 0, 800, 1, 12));
    tv.push_back(mk(64, 7, 13, 123, 999999900, 124, 100, -1, -1, 1, 0, 1, 0, 200, 1, 13));
    tv.push_back(mk(64, 7, 14, 121, 0, 124, 100, -1, -1, 1, 0, 1, 0, 0, 0, 14));
    tv.push_back(mk(64, 7, 15, 124, 500, 124, 100, -1, -1, 1, 0, 1, 0, 0, 0, 15));
    tv.push_back(mk(64, 7, 16, 123, 1000, 123, 1800, 0, -1, 0, 0, 0, 0, 0, 0, 16));
    tv.push_back(mk(64, 7, 16, 123, 1000, 123, 1800, -1, -1, 1, 0, 1, 0, 800, 1, 16));
    tv.push_back(mk(64, 7, 17, 123, 1000, 123, 1800, -1, 10, 1, 1, 0, 0, 0, 0, 17));
    tv.push_back(mk(20, 7, 17, 123, 1000, 123, 1800, -1, -1, 1, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(22, 7, 99, 123, 1000, 123, 1800, -1, -1, 1, 0, 0, 0, 0, 0, 99));
    tv.push_back(mk(63, 7, 17, 123, 1000, 123, 1800, -1, -1, 1, 0, 0, 0, 0, 0, 17));
    tv.push_back(mk(64, 7, 17, 123, 1000000000, 123, 1800, -1, -1, 1, 0, 0, 0, 0, 0, 17));
    tv.push_back(mk(64, 7, 17, 5, 0, 5, 7, -1, -1, 1, 0, 1, 0, 7, 1, 17));
    tv.push_back(mk(100, 1, 18, 5, 0, 5, 7, -1, -1, 1, 0, 1, 0, 7, 1, 18));

    rst = 1'b1; gmii_d = 8'h00; gmii_en = 1'b0; gmii_er = 1'b0; sec = '0; nsec = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset valid", 64'(o_valid), 64'd0);
    chk("reset size",  64'(o_frame_size), 64'd0);
    chk("reset seq",   o_seq, 64'd0);
    chk("reset lat",   64'(o_latency_nsec), 64'd0);
    rst = 1'b0;
    repeat (2) cyc(8'h00, 1'b0, 1'b0);

    for (int i = 0; i < tv.size(); i++) run_vec($sformatf("v%0d", i), tv[i]);

    // Back-to-back frames separated by the minimum single idle cycle.
    va = mk(64, 7, 19, 7, 50, 7, 100, -1, -1, 1, 0, 1, 0, 50, 1, 19);
    vb = mk(64, 7, 20, 7, 50, 7, 100, -1, -1, 1, 0, 1, 0, 50, 1, 20);
    sec = 7; nsec = 100;
    build_frame(va.len, va.seq, va.txs, va.txn, -1);
    drive_frame(7, -1);
    build_frame(vb.len, vb.seq, vb.txs, vb.txn, -1);
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h55, 1'b1, 1'b0);
    check_record("b2b_a", va);
    drive_frame(6, -1);
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b0);
    check_record("b2b_b", vb);
    repeat (10) cyc(8'h00, 1'b0, 1'b0);

    // Bad preamble byte, then preamble one byte too long: neither yields a record.
    p0 = pulses;
    cyc(8'h55, 1'b1, 1'b0);
    cyc(8'h00, 1'b1, 1'b0);
    repeat (30) cyc(8'h11, 1'b1, 1'b0);
    repeat (6) cyc(8'h00, 1'b0, 1'b0);
    chk("bad_pre pulses", 64'(pulses), 64'(p0));
    repeat (8) cyc(8'h55, 1'b1, 1'b0);
    cyc(8'hD5, 1'b1, 1'b0);
    repeat (30) cyc(8'h22, 1'b1, 1'b0);
    repeat (6) cyc(8'h00, 1'b0, 1'b0);
    chk("long_pre pulses", 64'(pulses), 64'(p0));

    // Reset in the middle of a frame, released while the frame is still running.
    sec = 5; nsec = 7;
    build_frame(64, 21, 5, 0, -1);
    repeat (7) cyc(8'h55, 1'b1, 1'b0);
    cyc(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cyc(fb[i], 1'b1, 1'b0);
    rst = 1'b1;
    cyc(fb[20], 1'b1, 1'b0);
    rst = 1'b0;
    for (int i = 21; i < fb.size(); i++) cyc(fb[i], 1'b1, 1'b0);
    repeat (6) cyc(8'h00, 1'b0, 1'b0);
    chk("rst pulses", 64'(pulses), 64'(p0));
    chk("rst valid",  64'(o_valid), 64'd0);
    chk("rst size",   64'(o_frame_size), 64'd0);
    chk("rst seq",    o_seq, 64'd0);
    chk("rst rx_sec", 64'(o_rx_sec), 64'd0);
    // Expected sequence was cleared by reset, so seq 0 is in order.
    vr = mk(64, 7, 0, 5, 0, 5, 7, -1, -1, 1, 0, 1, 0, 7, 1, 0);
    run_vec("post_rst", vr);

    chk("total pulses", 64'(pulses), 64'(tv.size() + 3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
